// File: rtl/ama_riscv_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_mem_arbiter_pkg
// Description : Shared types and constants for the main-memory arbiter that
//               sits between the icache/dcache refill paths and main memory.
//               Contents: FSM state enum, owner enum, request struct,
//               default widths, saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ama_riscv_mem_arbiter_pkg;

    localparam int MEM_ARB_ADDR_W = 26;   // line address (byte address >> 6)
    localparam int MEM_ARB_DATA_W = 512;  // one cache line

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        WAIT_RSP = 2'd2
    } mem_arb_state_t;

    // Encoding doubles as the grant-vector bit index: bit 0 = IC, bit 1 = DC.
    typedef enum logic {
        ARB_IC = 1'b0,
        ARB_DC = 1'b1
    } mem_arb_owner_t;

    typedef struct packed {
        logic                      wr;
        logic [MEM_ARB_ADDR_W-1:0] addr;
        logic [MEM_ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ama_riscv_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_rr_arb2
// Description : Two-input round-robin grant, purely combinational.
//               A lone requester always wins; on a tie the requester that
//               was not granted last time wins.
// Ports       : req[1:0]   in  request vector (bit 0 = IC, bit 1 = DC)
//               last       in  owner of the most recent grant
//               grant[1:0] out one-hot (or zero) grant vector
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_rr_arb2
    import ama_riscv_mem_arbiter_pkg::*;
(
    input  logic [1:0]     req,
    input  mem_arb_owner_t last,
    output logic [1:0]     grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == ARB_IC) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ama_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_mem_arbiter
// Description : Shares the single main-memory port between the icache refill
//               path and the dcache refill/writeback path. Round-robin grant,
//               one transaction outstanding, read data routed to the owner.
// Ports       : clk, rst (async, active high)
//               ic_req_*  icache line-read request (valid/ready)
//               ic_rsp_*  icache read data (one-cycle valid pulse)
//               dc_req_*  dcache read/writeback request (valid/ready)
//               dc_rsp_*  dcache read data (never pulses for writes)
//               mem_req_* request to memory (valid held until ready)
//               mem_rsp_* read data from memory
// Option      : AMA_RISCV_MEM_ARB_PERF_EN adds 32-bit saturating counters
//               arb_ic_grant_cnt, arb_dc_grant_cnt, arb_conflict_cnt and
//               arb_wait_cycles as extra output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_mem_arbiter
    import ama_riscv_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_rsp_valid,
    output logic [DATA_W-1:0] ic_rsp_data,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic              dc_req_wr,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_req_wdata,
    output logic              dc_rsp_valid,
    output logic [DATA_W-1:0] dc_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wr,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
`ifdef AMA_RISCV_MEM_ARB_PERF_EN
    ,
    output logic [31:0]       arb_ic_grant_cnt,
    output logic [31:0]       arb_dc_grant_cnt,
    output logic [31:0]       arb_conflict_cnt,
    output logic [31:0]       arb_wait_cycles
`endif
);

    mem_arb_state_t    r_state;
    mem_arb_state_t    w_state_nxt;
    mem_arb_owner_t    r_owner;
    mem_arb_owner_t    r_last_grant;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [1:0]        w_grant;
    logic              w_idle;
    logic              w_ic_fire;
    logic              w_dc_fire;

    ama_riscv_rr_arb2 u_rr_arb2 (
        .req   ({dc_req_valid, ic_req_valid}),
        .last  (r_last_grant),
        .grant (w_grant)
    );

    // Readies are also masked by rst so nothing looks accepted while the
    // caches themselves are being reset.
    assign w_idle       = (r_state == IDLE) && !rst;
    assign ic_req_ready = w_idle && w_grant[0];
    assign dc_req_ready = w_idle && w_grant[1];
    assign w_ic_fire    = ic_req_valid && ic_req_ready;
    assign w_dc_fire    = dc_req_valid && dc_req_ready;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        mem_req_valid = 1'b0;
        ic_rsp_valid  = 1'b0;
        dc_rsp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ic_fire || w_dc_fire) begin
                    w_state_nxt = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    // Writes complete on accept; only reads wait for data.
                    w_state_nxt = r_wr ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    ic_rsp_valid = (r_owner == ARB_IC);
                    dc_rsp_valid = (r_owner == ARB_DC);
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured request and round-robin history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= ARB_IC;
            r_last_grant <= ARB_DC;   // IC wins the first tie after reset
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_ic_fire || w_dc_fire) begin
            r_owner      <= w_dc_fire ? ARB_DC : ARB_IC;
            r_last_grant <= w_dc_fire ? ARB_DC : ARB_IC;
            r_wr         <= w_dc_fire && dc_req_wr;
            r_addr       <= w_dc_fire ? dc_req_addr : ic_req_addr;
            r_wdata      <= w_dc_fire ? dc_req_wdata : '0;
        end
    end

    assign mem_req_wr    = r_wr;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;

    // Read data is unbuffered; the rsp_valid pulses select the consumer.
    assign ic_rsp_data = mem_rsp_data;
    assign dc_rsp_data = mem_rsp_data;

    // Memory must only return data while a read is outstanding.
    a_rsp_only_in_wait : assert property (
        @(posedge clk) disable iff (rst)
        mem_rsp_valid |-> (r_state == WAIT_RSP)
    );

`ifdef AMA_RISCV_MEM_ARB_PERF_EN
    logic [31:0] r_ic_grant_cnt;
    logic [31:0] r_dc_grant_cnt;
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_wait_cycles;
    logic        w_conflict;
    logic        w_waiting;

    assign w_conflict = w_idle && ic_req_valid && dc_req_valid;
    assign w_waiting  = (ic_req_valid && !ic_req_ready) ||
                        (dc_req_valid && !dc_req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ic_grant_cnt <= '0;
            r_dc_grant_cnt <= '0;
            r_conflict_cnt <= '0;
            r_wait_cycles  <= '0;
        end else begin
            if (w_ic_fire)  r_ic_grant_cnt <= sat_inc32(r_ic_grant_cnt);
            if (w_dc_fire)  r_dc_grant_cnt <= sat_inc32(r_dc_grant_cnt);
            if (w_conflict) r_conflict_cnt <= sat_inc32(r_conflict_cnt);
            if (w_waiting)  r_wait_cycles  <= sat_inc32(r_wait_cycles);
        end
    end

    assign arb_ic_grant_cnt = r_ic_grant_cnt;
    assign arb_dc_grant_cnt = r_dc_grant_cnt;
    assign arb_conflict_cnt = r_conflict_cnt;
    assign arb_wait_cycles  = r_wait_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ama_riscv_mem_arbiter
// Description : Table-driven bench for ama_riscv_mem_arbiter. Each table row
//               is one clock cycle of inputs plus hand-computed outputs.
//               Reset-in-flight and perf counters (AMA_RISCV_MEM_ARB_PERF_EN)
//               are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_mem_arbiter;

    localparam int AW = 26;
    localparam int DW = 512;

    logic          clk;
    logic          rst;
    logic          ic_req_valid;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_rsp_valid;
    logic [DW-1:0] ic_rsp_data;
    logic          dc_req_valid;
    logic          dc_req_ready;
    logic          dc_req_wr;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_wdata;
    logic          dc_rsp_valid;
    logic [DW-1:0] dc_rsp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_wr;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
`ifdef AMA_RISCV_MEM_ARB_PERF_EN
    logic [31:0]   arb_ic_grant_cnt;
    logic [31:0]   arb_dc_grant_cnt;
    logic [31:0]   arb_conflict_cnt;
    logic [31:0]   arb_wait_cycles;
`endif

    ama_riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req_valid  (ic_req_valid),
        .ic_req_ready  (ic_req_ready),
        .ic_req_addr   (ic_req_addr),
        .ic_rsp_valid  (ic_rsp_valid),
        .ic_rsp_data   (ic_rsp_data),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_req_wr     (dc_req_wr),
        .dc_req_addr   (dc_req_addr),
        .dc_req_wdata  (dc_req_wdata),
        .dc_rsp_valid  (dc_rsp_valid),
        .dc_rsp_data   (dc_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wr    (mem_req_wr),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
`ifdef AMA_RISCV_MEM_ARB_PERF_EN
        ,
        .arb_ic_grant_cnt (arb_ic_grant_cnt),
        .arb_dc_grant_cnt (arb_dc_grant_cnt),
        .arb_conflict_cnt (arb_conflict_cnt),
        .arb_wait_cycles  (arb_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ic_v;
        logic [AW-1:0] ic_a;
        logic          dc_v;
        logic          dc_wr;
        logic [AW-1:0] dc_a;
        logic [7:0]    wd;      // writeback byte, replicated over the line
        logic          mr;
        logic          rv;
        logic [15:0]   rd;      // read-data halfword, replicated over the line
        logic          e_icrdy;
        logic          e_dcrdy;
        logic          e_mv;
        logic          e_mwr;
        logic [AW-1:0] e_ma;
        logic [7:0]    e_wd;
        logic          e_icr;
        logic          e_dcr;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(
        input logic ic_v, input logic [AW-1:0] ic_a,
        input logic dc_v, input logic dc_wr, input logic [AW-1:0] dc_a,
        input logic [7:0] wd, input logic mr, input logic rv,
        input logic [15:0] rd,
        input logic e_icrdy, input logic e_dcrdy, input logic e_mv,
        input logic e_mwr, input logic [AW-1:0] e_ma, input logic [7:0] e_wd,
        input logic e_icr, input logic e_dcr);
        vec_t v;
        v.ic_v = ic_v; v.ic_a = ic_a; v.dc_v = dc_v; v.dc_wr = dc_wr;
        v.dc_a = dc_a; v.wd = wd; v.mr = mr; v.rv = rv; v.rd = rd;
        v.e_icrdy = e_icrdy; v.e_dcrdy = e_dcrdy; v.e_mv = e_mv;
        v.e_mwr = e_mwr; v.e_ma = e_ma; v.e_wd = e_wd;
        v.e_icr = e_icr; v.e_dcr = e_dcr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ic_req_valid  = v.ic_v;
        ic_req_addr   = v.ic_a;
        dc_req_valid  = v.dc_v;
        dc_req_wr     = v.dc_wr;
        dc_req_addr   = v.dc_a;
        dc_req_wdata  = {64{v.wd}};
        mem_req_ready = v.mr;
        mem_rsp_valid = v.rv;
        mem_rsp_data  = {32{v.rd}};
    endtask

    task automatic check_row(input int i, input vec_t v);
        chk($sformatf("r%0d ic_req_ready", i), DW'(ic_req_ready), DW'(v.e_icrdy));
        chk($sformatf("r%0d dc_req_ready", i), DW'(dc_req_ready), DW'(v.e_dcrdy));
        chk($sformatf("r%0d mem_req_valid", i), DW'(mem_req_valid), DW'(v.e_mv));
        chk($sformatf("r%0d ic_rsp_valid", i), DW'(ic_rsp_valid), DW'(v.e_icr));
        chk($sformatf("r%0d dc_rsp_valid", i), DW'(dc_rsp_valid), DW'(v.e_dcr));
        if (v.e_mv) begin
            chk($sformatf("r%0d mem_req_wr", i), DW'(mem_req_wr), DW'(v.e_mwr));
            chk($sformatf("r%0d mem_req_addr", i), DW'(mem_req_addr), DW'(v.e_ma));
            if (v.e_mwr)
                chk($sformatf("r%0d mem_req_wdata", i), mem_req_wdata, {64{v.e_wd}});
        end
        if (v.e_icr) chk($sformatf("r%0d ic_rsp_data", i), ic_rsp_data, {32{v.rd}});
        if (v.e_dcr) chk($sformatf("r%0d dc_rsp_data", i), dc_rsp_data, {32{v.rd}});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ic_req_ready"}, DW'(ic_req_ready), '0);
        chk({tag, " dc_req_ready"}, DW'(dc_req_ready), '0);
        chk({tag, " mem_req_valid"}, DW'(mem_req_valid), '0);
        chk({tag, " mem_req_wr"}, DW'(mem_req_wr), '0);
        chk({tag, " mem_req_addr"}, DW'(mem_req_addr), '0);
        chk({tag, " mem_req_wdata"}, mem_req_wdata, '0);
        chk({tag, " ic_rsp_valid"}, DW'(ic_rsp_valid), '0);
        chk({tag, " dc_rsp_valid"}, DW'(dc_rsp_valid), '0);
    endtask

    initial begin
        // ---- vector table: one row per cycle --------------------------
        //            icv ica    dcv wr dca    wd     mr rv rd        ird drd mv mwr ma     ewd    icr dcr
        // Contention from the first cycle after reset: IC, DC, IC, DC, IC
        vq.push_back(mk(1, 'h10, 1, 0, 'h20, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(1, 'h11, 1, 0, 'h20, 8'h00, 1, 0, 16'h0000, 0, 0, 1, 0, 'h10, 8'h00, 0, 0));
        vq.push_back(mk(1, 'h11, 1, 0, 'h20, 8'h00, 0, 1, 16'h1111, 0, 0, 0, 0, 'h00, 8'h00, 1, 0));
        vq.push_back(mk(1, 'h11, 1, 0, 'h20, 8'h00, 0, 0, 16'h0000, 0, 1, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(1, 'h11, 1, 0, 'h21, 8'h00, 1, 0, 16'h0000, 0, 0, 1, 0, 'h20, 8'h00, 0, 0));
        vq.push_back(mk(1, 'h11, 1, 0, 'h21, 8'h00, 0, 1, 16'h2222, 0, 0, 0, 0, 'h00, 8'h00, 0, 1));
        vq.push_back(mk(1, 'h11, 1, 0, 'h21, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(1, 'h12, 1, 0, 'h21, 8'h00, 1, 0, 16'h0000, 0, 0, 1, 0, 'h11, 8'h00, 0, 0));
        vq.push_back(mk(1, 'h12, 1, 0, 'h21, 8'h00, 0, 1, 16'h3333, 0, 0, 0, 0, 'h00, 8'h00, 1, 0));
        vq.push_back(mk(1, 'h12, 1, 0, 'h21, 8'h00, 0, 0, 16'h0000, 0, 1, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(1, 'h12, 0, 0, 'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 1, 0, 'h21, 8'h00, 0, 0));
        vq.push_back(mk(1, 'h12, 0, 0, 'h00, 8'h00, 0, 1, 16'h4444, 0, 0, 0, 0, 'h00, 8'h00, 0, 1));
        vq.push_back(mk(1, 'h12, 0, 0, 'h00, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 1, 0, 'h12, 8'h00, 0, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 0, 1, 16'h5555, 0, 0, 0, 0, 'h00, 8'h00, 1, 0));
        // Single IC read of 0x40, memory latency 3
        vq.push_back(mk(1, 'h40, 0, 0, 'h00, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 1, 0, 'h40, 8'h00, 0, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 0, 1, 16'h6666, 0, 0, 0, 0, 'h00, 8'h00, 1, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 'h00, 8'h00, 0, 0));
        // DC writeback to 0x1F, memory stalls 5 cycles then accepts
        vq.push_back(mk(0, 'h00, 1, 1, 'h1F, 8'hA5, 0, 0, 16'h0000, 0, 1, 0, 0, 'h00, 8'h00, 0, 0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 0, 0, 16'h0000, 0, 0, 1, 1, 'h1F, 8'hA5, 0, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 1, 1, 'h1F, 8'hA5, 0, 0));
        // Back in IDLE right after the write accept: IC read of 0x50 granted
        vq.push_back(mk(1, 'h50, 0, 0, 'h00, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0, 'h00, 8'h00, 0, 0));
        vq.push_back(mk(0, 'h00, 0, 0, 'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 1, 0, 'h50, 8'h00, 0, 0));
        // WAIT_RSP: a new DC request is not accepted
        vq.push_back(mk(0, 'h00, 1, 0, 'h33, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 'h00, 8'h00, 0, 0));

        // ---- reset state ----------------------------------------------
        rst = 1'b1;
        drive(mk(1, 'h7, 1, 1, 'h9, 8'h3C, 1, 0, 16'h0, 0, 0, 0, 0, 'h0, 8'h0, 0, 0));
        #12;
        check_reset_outputs("rst0");
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- table --------------------------------------------------
        foreach (vq[i]) begin
            drive(vq[i]);
            @(negedge clk);
            check_row(i, vq[i]);
            @(posedge clk);
            #1;
        end

        // ---- reset while a read waits for its response ---------------
        rst = 1'b1;
        mem_rsp_valid = 1'b1;             // late data arriving during reset
        mem_rsp_data  = {32{16'hBEEF}};
        #1;
        check_reset_outputs("rst_wait");
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        ic_req_valid  = 1'b1;
        ic_req_addr   = 'h44;
        @(negedge clk);
        chk("rst_hold ic_req_ready", DW'(ic_req_ready), '0);
        chk("rst_hold dc_req_ready", DW'(dc_req_ready), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // Fresh round-robin history: IC wins the tie
        chk("post_rst ic_req_ready", DW'(ic_req_ready), DW'(1'b1));
        chk("post_rst dc_req_ready", DW'(dc_req_ready), '0);
        chk("post_rst mem_req_valid", DW'(mem_req_valid), '0);
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst idle ic_rsp_valid", DW'(ic_rsp_valid), '0);
        chk("post_rst idle dc_rsp_valid", DW'(dc_rsp_valid), '0);

`ifdef AMA_RISCV_MEM_ARB_PERF_EN
        // ---- 10 contended read pairs, 1-cycle memory -----------------
        begin
            int ic_n;
            int dc_n;
            logic pend;
            ic_n = 0;
            dc_n = 0;
            pend = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            ic_req_valid  = 1'b1;
            dc_req_valid  = 1'b1;
            dc_req_wr     = 1'b0;
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b0;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                if (ic_req_valid && ic_req_ready) ic_n++;
                if (dc_req_valid && dc_req_ready) dc_n++;
                pend = mem_req_valid && mem_req_ready;
                @(posedge clk);
                #1;
                ic_req_valid  = (ic_n < 10);
                dc_req_valid  = (dc_n < 10);
                ic_req_addr   = AW'(ic_n);
                dc_req_addr   = AW'(dc_n + 'h100);
                mem_rsp_valid = pend;
            end
            chk("perf transactions done", DW'(ic_n + dc_n), DW'(20));
            $display("arb stats: ic_grant=%0d dc_grant=%0d conflict=%0d wait=%0d",
                     arb_ic_grant_cnt, arb_dc_grant_cnt, arb_conflict_cnt,
                     arb_wait_cycles);
            chk("perf arb_ic_grant_cnt", DW'(arb_ic_grant_cnt), DW'(10));
            chk("perf arb_dc_grant_cnt", DW'(arb_dc_grant_cnt), DW'(10));
            // Every IDLE cycle but the last (DC alone) is a tie.
            chk("perf arb_conflict_cnt", DW'(arb_conflict_cnt), DW'(19));
            // 19 transactions x 3 cycles each have a requester left waiting.
            chk("perf arb_wait_cycles", DW'(arb_wait_cycles), DW'(57));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
